// File: rtl/report_pkg.sv
// Shared types and ASCII constants for the result reporter.
// The REPORT_HEX_EN build option is consumed by result_reporter, not here.
package report_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESENT,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_DONE
    } state_t;

    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    // Total frame bytes: "C", digit, ":", payload, CR, LF.
    function automatic logic [7:0] frame_len(input logic [7:0] len, input logic hex_en);
        return hex_en ? ((len << 1) + 8'd5) : (len + 8'd5);
    endfunction

endpackage

// File: rtl/hex_ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module hex_ascii
    import report_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) ascii = ASCII_ZERO + {4'h0, nibble};
        else                ascii = 8'h37 + {4'h0, nibble};
    end

endmodule

// File: rtl/result_reporter.sv
// Captures the winning cleartext and core ID, then streams a framed ASCII
// report to the USART over a send/sent handshake. Define REPORT_HEX_EN for hex payload.
module result_reporter
    import report_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int IDX_W   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 found,
    input  logic [8*MAX_LEN-1:0] cleartext,
    input  logic [3:0]           clear_len,
    input  logic                 core_id,
    input  logic                 rewind,
    input  logic                 tx_sent,
    output logic [7:0]           tx_byte,
    output logic                 tx_send,
    output logic                 busy,
    output logic                 done
);

`ifdef REPORT_HEX_EN
    localparam logic HEX_EN = 1'b1;
`else
    localparam logic HEX_EN = 1'b0;
`endif

    state_t               state, next_state;
    logic [IDX_W-1:0]     idx;
    logic [8*MAX_LEN-1:0] data_q;
    logic [7:0]           len_q;
    logic                 core_q;
    logic [7:0]           len_cap;
    logic [7:0]           sel_byte, payload_char, frame_byte;
    logic                 last_byte;
    int                   pos, byte_pos, payload_n;

    // Out-of-range lengths (including 0) mean "send the whole buffer".
    assign len_cap = (clear_len == 4'd0 || int'(clear_len) > MAX_LEN)
                   ? 8'(MAX_LEN) : {4'd0, clear_len};

    assign payload_n = int'(frame_len(len_q, HEX_EN)) - 5;
    assign last_byte = (int'(idx) == int'(frame_len(len_q, HEX_EN)) - 1);

    always_comb begin
        // NOTE: every combinational output is given a default first, so no path can infer a latch.
        pos      = int'(idx) - 3;
        byte_pos = HEX_EN ? (pos >>> 1) : pos;
        sel_byte = 8'h00;
        for (int i = 0; i < MAX_LEN; i++)
            if (byte_pos == i) sel_byte = data_q[8*(MAX_LEN-1-i) +: 8];
    end

`ifdef REPORT_HEX_EN
    logic [3:0] nibble;
    assign nibble = pos[0] ? sel_byte[3:0] : sel_byte[7:4];
    hex_ascii u_hex (
        .nibble (nibble),
        .ascii  (payload_char)
    );
`else
    assign payload_char = sel_byte;
`endif

    always_comb begin
        frame_byte = ASCII_LF;
        if      (pos == -3)       frame_byte = ASCII_C;
        else if (pos == -2)       frame_byte = ASCII_ZERO + {7'd0, core_q};
        else if (pos == -1)       frame_byte = ASCII_COLON;
        else if (pos < payload_n) frame_byte = payload_char;
        else if (pos == payload_n) frame_byte = ASCII_CR;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (found)    next_state = S_PRESENT;
            S_PRESENT:   if (tx_sent)  next_state = S_WAIT_LOW;
            S_WAIT_LOW:  if (!tx_sent) next_state = S_WAIT_HIGH;
            S_WAIT_HIGH: if (tx_sent)  next_state = last_byte ? S_DONE : S_PRESENT;
            S_DONE:      if (rewind)   next_state = S_PRESENT;
            default:                   next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            // NOTE: the capture registers are reset too, so a replay can never expose X.
            data_q  <= '0;
            len_q   <= '0;
            core_q  <= 1'b0;
            tx_byte <= 8'h00;
            tx_send <= 1'b0;
        end else begin
            state   <= next_state;
            tx_send <= 1'b0;
            case (state)
                S_IDLE: if (found) begin
                    data_q <= cleartext;
                    len_q  <= len_cap;
                    core_q <= core_id;
                    idx    <= '0;
                end
                S_PRESENT: if (tx_sent) begin
                    tx_byte <= frame_byte;
                    tx_send <= 1'b1;
                end
                S_WAIT_HIGH: if (tx_sent) idx <= idx + 1'b1;
                S_DONE:      if (rewind)  idx <= '0;
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_result_reporter.sv
// Directed bench for result_reporter with a simple USART handshake model.
module tb_result_reporter;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        found = 1'b0;
    logic [63:0] cleartext = '0;
    logic [3:0]  clear_len = '0;
    logic        core_id = 1'b0;
    logic        rewind = 1'b0;
    logic        tx_sent = 1'b1;
    logic [7:0]  tx_byte;
    logic        tx_send, busy, done;

    int      checks = 0, errors = 0;
    int      pulses = 0, stable_err = 0, double_err = 0;
    int      busy_cycles = 2;
    byte_q_t rx_q;
    byte_q_t exp_abc, exp_full;

    result_reporter #(.MAX_LEN(8), .IDX_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .found     (found),
        .cleartext (cleartext),
        .clear_len (clear_len),
        .core_id   (core_id),
        .rewind    (rewind),
        .tx_sent   (tx_sent),
        .tx_byte   (tx_byte),
        .tx_send   (tx_send),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // USART model: accepts a byte on tx_send, stays busy for busy_cycles.
    always begin
        logic [7:0] b;
        @(negedge clk);
        if (tx_send === 1'b1) begin
            b = tx_byte;
            rx_q.push_back(b);
            pulses++;
            tx_sent = 1'b0;
            repeat (busy_cycles) begin
                @(negedge clk);
                if (tx_byte !== b)    stable_err++;
                if (tx_send !== 1'b0) double_err++;
            end
            tx_sent = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_frame(input string tag, input byte_q_t exp);
        logic [7:0] got;
        check({tag, "_count"}, pulses, exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            check($sformatf("%s_b%0d", tag, i), {24'd0, got}, {24'd0, exp[i]});
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, done, 1);
    endtask

    task automatic clear_log();
        rx_q.delete();
        pulses     = 0;
        stable_err = 0;
        double_err = 0;
    endtask

    task automatic pulse_inputs(input logic f, input logic r);
        @(negedge clk);
        found  = f;
        rewind = r;
        @(negedge clk);
        found  = 1'b0;
        rewind = 1'b0;
    endtask

    initial begin
`ifdef REPORT_HEX_EN
        exp_abc  = '{8'h43, 8'h30, 8'h3A, 8'h36, 8'h31, 8'h36, 8'h32, 8'h36, 8'h33, 8'h0D, 8'h0A};
        exp_full = '{8'h43, 8'h31, 8'h3A, 8'h34, 8'h31, 8'h34, 8'h32, 8'h34, 8'h33, 8'h34, 8'h34,
                     8'h34, 8'h35, 8'h34, 8'h36, 8'h34, 8'h37, 8'h34, 8'h38, 8'h0D, 8'h0A};
`else
        exp_abc  = '{8'h43, 8'h30, 8'h3A, 8'h61, 8'h62, 8'h63, 8'h0D, 8'h0A};
        exp_full = '{8'h43, 8'h31, 8'h3A, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48,
                     8'h0D, 8'h0A};
`endif
        repeat (3) @(negedge clk);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_tx_send", tx_send, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        // Raw frame "abc" with a fast USART; trailing bytes must be ignored.
        @(negedge clk);
        cleartext = "abcXYZWV";
        clear_len = 4'd3;
        core_id   = 1'b0;
        found     = 1'b1;
        @(negedge clk);
        found = 1'b0;
        check("lat_busy", busy, 1);
        check("lat_send_early", tx_send, 0);
        @(negedge clk);
        check("lat_send", tx_send, 1);
        check("lat_byte", tx_byte, 8'h43);
        // Second hit and a rewind mid-frame must both be ignored.
        cleartext = "zzzzzzzz";
        core_id   = 1'b1;
        pulse_inputs(1'b1, 1'b1);
        wait_done("frame1_done", 300);
        check_frame("frame1", exp_abc);
        check("frame1_busy", busy, 0);

        // Another hit while in DONE: nothing is sent.
        clear_log();
        pulse_inputs(1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("done_found_pulses", pulses, 0);
        check("done_found_done", done, 1);

        // Replay from DONE reuses the latched data.
        clear_log();
        pulse_inputs(1'b0, 1'b1);
        check("rewind_busy", busy, 1);
        wait_done("rewind_done", 300);
        check_frame("rewind", exp_abc);

        // Slow USART, found and rewind together: rewind wins, one strobe per byte.
        busy_cycles = 200;
        clear_log();
        pulse_inputs(1'b1, 1'b1);
        wait_done("slow_done", 4000);
        check_frame("slow", exp_abc);
        check("slow_stable", stable_err, 0);
        check("slow_single_strobe", double_err, 0);

        // Reset after the second byte aborts the frame immediately.
        busy_cycles = 2;
        clear_log();
        pulse_inputs(1'b0, 1'b1);
        begin
            int n = 0;
            while (pulses < 2 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("abort_two_bytes", pulses, 2);
        reset = 1'b1;
        #1;
        check("abort_tx_byte", tx_byte, 8'h00);
        check("abort_tx_send", tx_send, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_resume", pulses, 2);

        // clear_len = 0 selects the full MAX_LEN payload.
        clear_log();
        cleartext = "ABCDEFGH";
        clear_len = 4'd0;
        core_id   = 1'b1;
        pulse_inputs(1'b1, 1'b0);
        wait_done("full_done", 500);
        check_frame("full", exp_full);

`ifdef REPORT_HEX_EN
        begin
            byte_q_t exp_j;
            exp_j = '{8'h43, 8'h31, 8'h3A, 8'h36, 8'h41, 8'h0D, 8'h0A};
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            repeat (5) @(negedge clk);
            clear_log();
            cleartext = {8'h6A, 56'h0};
            clear_len = 4'd1;
            core_id   = 1'b1;
            pulse_inputs(1'b1, 1'b0);
            wait_done("hex_done", 300);
            check_frame("hex", exp_j);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
